m2_ws: RTL

//  Milestone-2 write-back stage: consumes one 8x8 block of S (IDCT output) held in the embedded
//  DP-RAM at S_OFFSET, clips each value to 0..255, packs two pixels per 16-bit word and writes the
//  32 words to external SRAM at the block's pre-IDCT (YUV) location. Runs after m2_cs fills S.

---
 rtl/m2_pkg.sv | 18 +
 rtl/m2_clip8.sv | 23 ++
 rtl/m2_ws.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/m2_pkg.sv
// rtl/m2_pkg.sv - shared types and constants for the milestone-2 write-back stage
package m2_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_IN_0  = 3'd1,
        S_LEAD_IN_1  = 3'd2,
        S_COMMON_0   = 3'd3,
        S_COMMON_1   = 3'd4,
        S_LEAD_OUT_0 = 3'd5
    } m2_ws_state_t;

    localparam int S_OFFSET     = 64;
    localparam int ROW_WORDS_Y  = 160;
    localparam int ROW_WORDS_UV = 80;
    localparam int BLOCK_WORDS  = 32;

endpackage

// File: rtl/m2_clip8.sv
// rtl/m2_clip8.sv - combinational signed 32-bit to unsigned 8-bit pixel clip
//   value   in  32  signed IDCT sample
//   pixel   out 8   value clamped to 0..255
//   clipped out 1   value was outside 0..255
module m2_clip8 (
    input  logic signed [31:0] value,
    output logic        [7:0]  pixel,
    output logic               clipped
);

    always_comb begin
        pixel   = value[7:0];
        clipped = 1'b0;
        if (value < 32'sd0) begin
            pixel   = 8'h00;
            clipped = 1'b1;
        end else if (value > 32'sd255) begin
            pixel   = 8'hFF;
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/m2_ws.sv
// rtl/m2_ws.sv - write-back stage: clip one 8x8 S block from DP-RAM, pack pixel pairs, write to SRAM; optional clip_count under M2_WS_CLIP_COUNT_EN
//   CLOCK_50        in  1   clock
//   Reset           in  1   synchronous active-high reset
//   Start           in  1   level request, accepted in S_IDLE when Done is low
//   base_address    in  18  plane origin in SRAM words
//   block_row       in  5   block row index
//   block_col       in  6   block column index
//   read_data_S_a   in  32  DP-RAM port A read data
//   address_S_a     out 7   DP-RAM port A address
//   SRAM_address    out 18  SRAM word address
//   SRAM_write_data out 16  {even pixel, odd pixel}
//   SRAM_we_n       out 1   active-low SRAM write enable
//   Done            out 1   block complete, held until Start drops
//   clip_count      out 7   clipped samples in last block (M2_WS_CLIP_COUNT_EN only)
module m2_ws #(
    parameter int S_OFFSET  = m2_pkg::S_OFFSET,
    parameter int ROW_WORDS = m2_pkg::ROW_WORDS_Y
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] base_address,
    input  logic [4:0]  block_row,
    input  logic [5:0]  block_col,
    input  logic [31:0] read_data_S_a,
    output logic [6:0]  address_S_a,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done
`ifdef M2_WS_CLIP_COUNT_EN
    ,
    output logic [6:0]  clip_count
`endif
);

    import m2_pkg::*;

    localparam logic [6:0]  ADDR_FIRST = 7'(S_OFFSET);
    localparam logic [6:0]  ADDR_LAST  = 7'(S_OFFSET + 63);
    localparam logic [17:0] ROW_STEP   = 18'(ROW_WORDS);
    localparam logic [17:0] ROW_BLOCK  = 18'(8 * ROW_WORDS);

    m2_ws_state_t state;

    logic [5:0]  samp_k;      // index of the S sample arriving on read_data_S_a this cycle
    logic [17:0] row_base;    // SRAM address of column 0 of the current block row
    logic [7:0]  even_pix;
    logic [17:0] row_start;
    logic        accept;

    logic [7:0]  even_clip_pix;
    logic [7:0]  odd_clip_pix;
    logic        even_clipped;
    logic        odd_clipped;

    assign accept = (state == S_IDLE) && Start && !Done;

    // Multiply only at accept time; the per-row advance inside the block is an add.
    assign row_start = base_address
                     + 18'(block_row) * ROW_BLOCK
                     + 18'({block_col, 2'b00});

    m2_clip8 u_clip_even (
        .value   (read_data_S_a),
        .pixel   (even_clip_pix),
        .clipped (even_clipped)
    );

    m2_clip8 u_clip_odd (
        .value   (read_data_S_a),
        .pixel   (odd_clip_pix),
        .clipped (odd_clipped)
    );

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state           <= S_IDLE;
            Done            <= 1'b0;
            SRAM_we_n       <= 1'b1;
            address_S_a     <= 7'd0;
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
            samp_k          <= 6'd0;
            row_base        <= 18'd0;
            even_pix        <= 8'd0;
        end else begin
            // Read addresses stream one per edge and park on the last S word.
            if (state != S_IDLE && state != S_LEAD_OUT_0 && address_S_a != ADDR_LAST) begin
                address_S_a <= address_S_a + 7'd1;
            end

            case (state)
                S_IDLE: begin
                    if (!Start) begin
                        Done <= 1'b0;
                    end else if (!Done) begin
                        address_S_a <= ADDR_FIRST;
                        row_base    <= row_start;
                        samp_k      <= 6'd0;
                        state       <= S_LEAD_IN_0;
                    end
                end

                S_LEAD_IN_0: begin
                    state <= S_LEAD_IN_1;
                end

                // Even sample: buffer it and release the previous write strobe.
                S_LEAD_IN_1, S_COMMON_1: begin
                    even_pix  <= even_clip_pix;
                    SRAM_we_n <= 1'b1;
                    samp_k    <= samp_k + 6'd1;
                    state     <= S_COMMON_0;
                end

                // Odd sample: completes a pixel pair, issue the SRAM write.
                S_COMMON_0: begin
                    SRAM_write_data <= {even_pix, odd_clip_pix};
                    SRAM_address    <= row_base + {16'd0, samp_k[2:1]};
                    SRAM_we_n       <= 1'b0;
                    samp_k          <= samp_k + 6'd1;
                    if (samp_k[2:0] == 3'd7) begin
                        row_base <= row_base + ROW_STEP;
                    end
                    state <= (samp_k == 6'd63) ? S_LEAD_OUT_0 : S_COMMON_1;
                end

                S_LEAD_OUT_0: begin
                    SRAM_we_n <= 1'b1;
                    Done      <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef M2_WS_CLIP_COUNT_EN
    logic sample_clipped;

    always_comb begin
        sample_clipped = 1'b0;
        case (state)
            S_LEAD_IN_1, S_COMMON_1: sample_clipped = even_clipped;
            S_COMMON_0:              sample_clipped = odd_clipped;
            default:                 sample_clipped = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            clip_count <= 7'd0;
        end else if (accept) begin
            clip_count <= 7'd0;
        end else if (sample_clipped) begin
            clip_count <= clip_count + 7'd1;
        end
    end
`else
    logic unused_clip_flags;
    assign unused_clip_flags = even_clipped ^ odd_clipped ^ accept;
`endif

endmodule
